// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART done-detect slice
package uart_pkg;

  typedef enum logic {ST_IDLE, ST_COLLECT} done_state_e;

  localparam int DONE_N_CH      = 2;
  localparam int DONE_TIMEOUT_W = 16;

endpackage

// File: rtl/uart_chan_latch.sv
// rtl/uart_chan_latch.sv - per-channel event detect, sticky seen flag and duplicate pulse
module uart_chan_latch #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_mask,
  input  logic i_clear,
  input  logic i_consume,
  output logic o_ev,
  output logic o_flag,
  output logic o_dup
);

  logic en_q;

  assign o_ev = i_mask & (EDGE_MODE ? (i_en & ~en_q) : i_en);

  // en_q tracks i_en unconditionally so an abort never hides a later edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q   <= 1'b0;
      o_flag <= 1'b0;
      o_dup  <= 1'b0;
    end else begin
      en_q  <= i_en;
      o_dup <= o_ev & o_flag & ~i_clear;
      if (i_consume)
        o_flag <= 1'b0;
      else if (o_ev)
        o_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_multi_done_detect.sv
// rtl/uart_multi_done_detect.sv - N-channel completion detector with mask, timeout and abort
module uart_multi_done_detect
  import uart_pkg::*;
#(
  parameter int N_CH      = DONE_N_CH,
  parameter int TIMEOUT_W = DONE_TIMEOUT_W,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_CH-1:0]      i_en,
  input  logic [N_CH-1:0]      i_ch_mask,
  input  logic                 i_clear,
  input  logic [TIMEOUT_W-1:0] i_timeout_lim,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [N_CH-1:0]      o_dup,
  output logic [N_CH-1:0]      o_pending,
  output logic                 o_busy
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  done_state_e          state, state_d;
  logic [TIMEOUT_W-1:0] cnt, cnt_d;
  logic [N_CH-1:0]      ev, flags;
  logic                 consume, done_d, to_d, all_seen, to_hit;

  for (genvar k = 0; k < N_CH; k++) begin : gen_ch
    uart_chan_latch #(.EDGE_MODE(EDGE_MODE)) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en[k]),
      .i_mask    (i_ch_mask[k]),
      .i_clear   (i_clear),
      .i_consume (consume),
      .o_ev      (ev[k]),
      .o_flag    (flags[k]),
      .o_dup     (o_dup[k])
    );
  end

  // Same-cycle events count toward completion, so completion needs no extra cycle
  assign all_seen = (|i_ch_mask) & (&(flags | ev | ~i_ch_mask));
  assign to_hit   = (state == ST_COLLECT) && (i_timeout_lim != '0) &&
                    (cnt == i_timeout_lim - CNT_ONE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    consume = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    if (i_clear) begin
      consume = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (all_seen) begin
      done_d  = 1'b1;
      consume = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (to_hit) begin
      to_d    = 1'b1;
      consume = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (state == ST_IDLE) begin
      cnt_d = '0;
      if (|ev)
        state_d = ST_COLLECT;
    end else if (cnt != CNT_MAX) begin
      cnt_d = cnt + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      o_done    <= done_d;
      o_timeout <= to_d;
    end
  end

  assign o_pending = flags;
  assign o_busy    = (state == ST_COLLECT);

endmodule

// File: tb/tb_uart_multi_done_detect.sv
// tb/tb_uart_multi_done_detect.sv - randomized scoreboard bench for uart_multi_done_detect
module tb_uart_multi_done_detect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  en = 4'h0;
  logic [3:0]  mask = 4'h0;
  logic        clr = 1'b0;
  logic [15:0] lim = 16'd0;

  logic       done4, to4, busy4;
  logic [3:0] dup4, pend4;
  logic       done2, to2, busy2;
  logic [1:0] dup2, pend2;

  always #5 clk = ~clk;

  uart_multi_done_detect #(.N_CH(4), .TIMEOUT_W(16), .EDGE_MODE(1'b1)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ch_mask(mask), .i_clear(clr),
    .i_timeout_lim(lim), .o_done(done4), .o_timeout(to4), .o_dup(dup4),
    .o_pending(pend4), .o_busy(busy4)
  );

  uart_multi_done_detect #(.N_CH(2), .TIMEOUT_W(16), .EDGE_MODE(1'b0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1:0]), .i_ch_mask(mask[1:0]), .i_clear(clr),
    .i_timeout_lim(lim), .o_done(done2), .o_timeout(to2), .o_dup(dup2),
    .o_pending(pend2), .o_busy(busy2)
  );

  typedef struct {
    logic [3:0]  seen;
    logic [3:0]  prev;
    bit          busy;
    int unsigned elapsed;
  } mdl_t;

  typedef struct {
    int         tag;
    logic [10:0] v;
  } exp_t;

  mdl_t m4, m2;
  exp_t q4[$], q2[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Returns {done, timeout, dup[3:0], pending[3:0], busy} as seen after the clock edge
  function automatic logic [10:0] step(inout mdl_t m, input logic [3:0] en_v,
                                       input logic [3:0] mask_v, input logic clr_v,
                                       input logic [15:0] lim_v, input bit edge_m,
                                       input int nch);
    logic [3:0] used, msk, ev, dup;
    bit done, tmo, all;
    used = 4'((1 << nch) - 1);
    msk  = mask_v & used;
    done = 0;
    tmo  = 0;
    ev   = msk & (edge_m ? (en_v & ~m.prev) : en_v);
    m.prev = en_v & used;
    all  = (msk != 4'h0) && (((m.seen | ev | ~msk) | ~used) == 4'hF);
    dup  = clr_v ? 4'h0 : (ev & m.seen);
    if (clr_v) begin
      m.seen = 0; m.busy = 0; m.elapsed = 0;
    end else if (all) begin
      done = 1; m.seen = 0; m.busy = 0; m.elapsed = 0;
    end else if (m.busy && lim_v != 0 && m.elapsed == 32'(lim_v) - 1) begin
      tmo = 1; m.seen = 0; m.busy = 0; m.elapsed = 0;
    end else begin
      m.seen = m.seen | ev;
      if (m.busy) begin
        if (m.elapsed < 65535) m.elapsed = m.elapsed + 1;
      end else if (ev != 4'h0) begin
        m.busy = 1;
        m.elapsed = 0;
      end
    end
    return {done, tmo, dup, m.seen, m.busy};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: {done,timeout,dup,pending,busy} actual=%b required=%b",
               name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [10:0] act4();
    return {done4, to4, dup4, pend4, busy4};
  endfunction

  function automatic logic [10:0] act2();
    return {done2, to2, 2'b00, dup2, 2'b00, pend2, busy2};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (q4.size() > 0 && q4[0].tag == edge_cnt) check("dut4", act4(), q4.pop_front().v);
      if (q2.size() > 0 && q2[0].tag == edge_cnt) check("dut2", act2(), q2.pop_front().v);
    end
  end

  task automatic reset_models();
    m4 = '{seen: 4'h0, prev: 4'h0, busy: 0, elapsed: 0};
    m2 = '{seen: 4'h0, prev: 4'h0, busy: 0, elapsed: 0};
    q4.delete();
    q2.delete();
  endtask

  // Called just after a rising edge; drives the next cycle and records its expected result
  task automatic drive_cycle(input int rate);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, rate) == 0) en[i] = ~en[i];
    clr = ($urandom_range(0, 29) == 0);
    if ($urandom_range(0, 39) == 0) mask = 4'($urandom_range(0, 15));
    q4.push_back('{tag: edge_cnt + 1, v: step(m4, en, mask, clr, lim, 1'b1, 4)});
    q2.push_back('{tag: edge_cnt + 1, v: step(m2, en, mask, clr, lim, 1'b0, 2)});
  endtask

  initial begin
    int rate;
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    check("reset4", act4(), 11'h0);
    check("reset2", act2(), 11'h0);
    mask = 4'hF;
    lim  = 16'd8;
    en   = 4'b0001;
    rst_n = 1'b1;
    drive_cycle(1000);
    for (int phase = 0; phase < 8; phase++) begin
      rate = $urandom_range(2, 10);
      lim  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
      repeat (400) begin
        @(posedge clk);
        #1;
        drive_cycle(rate);
      end
      @(posedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      check("async_reset4", act4(), 11'h0);
      check("async_reset2", act2(), 11'h0);
      reset_models();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_cycle(rate);
    end
    @(posedge clk);
    #6;
    n_checks++;
    if (q4.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual unchecked entries=%0d required 0", q4.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_multi_done_detect.md
# uart_multi_done_detect

Parametrised N-channel completion detector for the UART floating-point datapath. It latches a sticky "seen" flag per channel when that channel's enable fires, and pulses `o_done` once every unmasked channel has been seen; after `o_done` it re-arms for the next transaction. It generalises the two-operand done detector with:
- a configurable channel count and per-channel mask;
- edge or level event mode;
- a collection timeout;
- duplicate-event reporting;
- a synchronous abort.

## Interface
- `N_CH`, 2, number of channels (≥1)
- `TIMEOUT_W`, 16, width of timeout counter and limit
- `EDGE_MODE`, 1, 1 = event is rising edge of `i_en[k]`; 0 = event is `i_en[k]` level high

- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_en`  in  N_CH  per-channel enable/valid
- `i_ch_mask`  in  N_CH  1 = channel participates in completion
- `i_clear`  in  1  synchronous abort
- `i_timeout_lim`  in  TIMEOUT_W  collection timeout in cycles; 0 = disabled
- `o_done`  out  1  one-cycle completion pulse
- `o_timeout`  out  1  one-cycle timeout pulse
- `o_dup`  out  N_CH  one-cycle pulse: event on an already-latched channel
- `o_pending`  out  N_CH  latched seen flags
- `o_busy`  out  1  high while in COLLECT

## Operation
- **Event definition.**
  - Channel event: `ev[k] = i_ch_mask[k] & (EDGE_MODE ? i_en[k] & ~en_q[k] : i_en[k])`.
  - `en_q` is the registered previous `i_en`. It updates every cycle, including during `i_clear`.
- **Completion term.** `all_seen = (i_ch_mask != 0) & &(flags | ev | ~i_ch_mask)`.
- **FSM states:** IDLE, COLLECT.
- **Transition priority**, highest first, evaluated each cycle:
  1. `i_clear`: flags ← 0, cnt ← 0, state ← IDLE. No `o_done`, `o_timeout` or `o_dup`.
  2. `all_seen`: `o_done` ← 1, flags ← 0, cnt ← 0, state ← IDLE. Events in this cycle are consumed by this completion.
  3. In COLLECT with `i_timeout_lim != 0` and `cnt == i_timeout_lim-1`: `o_timeout` ← 1, flags ← 0, state ← IDLE.
  4. Otherwise: flags ← flags | ev. State moves IDLE→COLLECT on any ev. In COLLECT, cnt increments.
- **Duplicates.** `o_dup[k]` ← `ev[k] & flags[k] & ~i_clear`. This is independent of completion or timeout in the same cycle.
- **Masked channels** are neither latched nor reported as duplicates.
- **Mask changes** take effect immediately. If clearing mask bits in COLLECT makes `all_seen` true, `o_done` fires with no new event.
- **All-zero mask:** the block never fires `o_done`. Latched flags are held until timeout or clear.
- **Level mode:** a held-high channel raises `o_dup` every cycle after it is latched.

## Timing
- **Reset values:** all outputs 0, state IDLE, flags 0, cnt 0, `en_q` 0.
  - In edge mode, an `i_en` that is high at reset release counts as an event on the first clock.
- **Output registration:**
  - `o_done`, `o_timeout`, `o_dup` are registered: they go high 1 cycle after the causing cycle, for exactly 1 cycle.
  - `o_pending` = flags; `o_busy` = (state == COLLECT).
- **Latency:** last required event at cycle t → `o_done` at t+1. With `N_CH=1`, an event at t gives `o_done` at t+1 and the block never enters COLLECT.
- **Timeout:** first event at t (not completing) → COLLECT with cnt=0 at t+1 → `o_timeout` at t+1+lim. The block is IDLE in that cycle.
- **Same-cycle collisions:**
  - Completion and timeout in the same cycle: completion wins.
  - Clear together with anything: clear wins.
- **Re-arm:** an event in the cycle where `o_done` is high starts a new collection.
- **Asynchronous reset mid-collection** discards all flags immediately.
- **Counter width:** cnt is `TIMEOUT_W` bits and never wraps, because timeout fires at `lim-1`. With lim=0, cnt saturates at all-ones.

## Structure
- **Shared package `uart_pkg`:**
  - `typedef enum logic {ST_IDLE, ST_COLLECT} done_state_e`
  - Default parameter constants `DONE_N_CH`, `DONE_TIMEOUT_W`
- **Sub-module `uart_chan_latch`:** one per channel, generated `N_CH` times.
  - Contains the edge detect (`en_q`), sticky flag and dup pulse.
  - Inputs: clear/consume strobe and mask bit. Outputs: ev, flag, dup.
- **Top level** holds the FSM, timeout counter, `all_seen` reduction and output registers.

## Test plan
- **Basic completion:** `N_CH=2`, mask=11, edge mode. Pulse `i_en[0]` at cycle 5 and `i_en[1]` at cycle 9 → `o_pending`=01 from cycle 6, `o_done`=1 at cycle 10 only, `o_busy` 6–9, then `o_pending`=00.
- **Simultaneous events and mask:** `N_CH=4`, mask=1011. Events on channels 0, 1 and 3 in the same cycle t → `o_done` at t+1. Channel 2 events are ignored and never raise `o_dup[2]`.
- **Timeout:** lim=8. Event on channel 0 only at t → `o_timeout` at t+9, no `o_done`, flags cleared. A channel 1 event at t+9 starts a fresh COLLECT.
- **Duplicate:** channel 0 pulses twice before channel 1 → `o_dup[0]` one cycle after the second pulse, and `o_done` still fires after channel 1.
- **Priority:** `i_clear` asserted in the same cycle as the completing event → no `o_done`, state IDLE. Completion coinciding with `cnt == lim-1` → `o_done`=1, `o_timeout`=0.
- **Reset and level mode:** `EDGE_MODE=0`, hold `i_en[0]` high → `o_dup[0]` every cycle after latch. Asserting `i_rst_n`=0 mid-COLLECT → all outputs 0 asynchronously.
